// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit arbiter slice:
//   - default requester count and HOLD watchdog limit
//   - arbiter state encoding
//   - idx_width(): width of an index able to address n requesters
// No ports (package).
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int UART_NUM_REQ_DEF      = 4;
  localparam int UART_HOLD_TIMEOUT_DEF = 1024;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_HOLD      = 3'd4
  } arb_state_e;

  // Index width for n requesters; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// -----------------------------------------------------------------------------
// uart_rr_pick
// Combinational round-robin selector. The search starts at last_owner+1 and
// wraps around; the first requester found is returned one-hot.
// Ports:
//   req        [NUM_REQ-1:0]  pending requests
//   last_owner [IW-1:0]       index of the previously served requester
//   pick       [NUM_REQ-1:0]  one-hot winner, zero when req is zero
// -----------------------------------------------------------------------------
module uart_rr_pick
  import uart_pkg::*;
#(
  parameter int NUM_REQ = UART_NUM_REQ_DEF
) (
  input  logic [NUM_REQ-1:0]            req,
  input  logic [idx_width(NUM_REQ)-1:0] last_owner,
  output logic [NUM_REQ-1:0]            pick
);

  int   sum_s;
  int   cand_s;
  logic found_s;
  logic hit_s;

  // Walk candidates in priority order; the outer loop visits offsets
  // 1..NUM_REQ from last_owner, the inner loop keeps every index constant.
  always_comb begin
    pick    = {NUM_REQ{1'b0}};
    found_s = 1'b0;
    hit_s   = 1'b0;
    sum_s   = 0;
    cand_s  = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      sum_s  = int'(last_owner) + i;
      cand_s = (sum_s >= NUM_REQ) ? (sum_s - NUM_REQ) : sum_s;
      for (int k = 0; k < NUM_REQ; k++) begin
        hit_s   = !found_s && req[k] && (cand_s == k);
        pick[k] = pick[k] | hit_s;
        found_s = found_s | hit_s;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte
// sources. A granted requester keeps ownership until it delivers a byte marked
// last, so packets are never interleaved.
// Optional feature: define UART_ARB_TIMEOUT_EN to enable a HOLD watchdog that
// revokes an owner which stalls mid-packet for HOLD_TIMEOUT cycles.
// Ports:
//   clk50m       system clock, rising edge
//   reset_n      asynchronous active-low reset
//   req          per-requester request, held until req_ack
//   req_last     presented byte is the last of its packet
//   req_data     byte i on bits [8i+7:8i]
//   req_ack      one-cycle pulse when a byte is taken
//   grant        one-hot current owner, zero when idle
//   tx_data      byte to the transmitter, stable between acceptances
//   tx_start     one-cycle launch pulse
//   tx_busy      transmitter busy (already synchronous to clk50m)
//   timeout_err  one-cycle pulse when the watchdog revokes an owner
// -----------------------------------------------------------------------------
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ      = UART_NUM_REQ_DEF,
  parameter int HOLD_TIMEOUT = UART_HOLD_TIMEOUT_DEF
) (
  input  logic                 clk50m,
  input  logic                 reset_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ-1:0]   req_last,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ack,
  output logic [NUM_REQ-1:0]   grant,
  output logic [7:0]           tx_data,
  output logic                 tx_start,
  input  logic                 tx_busy,
  output logic                 timeout_err
);

  localparam int IW = idx_width(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || HOLD_TIMEOUT < 1) begin : g_param_check
    $error("uart_tx_arbiter: NUM_REQ must be 2..8 and HOLD_TIMEOUT at least 1");
  end

  arb_state_e         state_r;
  arb_state_e         next_state_s;
  logic [IW-1:0]      last_owner_r;
  logic               last_flag_r;
  logic [NUM_REQ-1:0] pick_s;
  logic               owner_req_s;
  logic               owner_last_s;
  logic [7:0]         owner_data_s;
  logic [IW-1:0]      owner_idx_s;
  logic               timeout_hit_s;

  logic [NUM_REQ-1:0] grant_nxt_s;
  logic [NUM_REQ-1:0] ack_nxt_s;
  logic               start_nxt_s;
  logic [7:0]         data_nxt_s;
  logic [IW-1:0]      last_owner_nxt_s;
  logic               last_flag_nxt_s;

  uart_rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req        (req),
    .last_owner (last_owner_r),
    .pick       (pick_s)
  );

  // View of the current owner's request lines, selected by the one-hot grant.
  always_comb begin
    owner_req_s  = |(req & grant);
    owner_last_s = |(req_last & grant);
    owner_data_s = 8'h00;
    owner_idx_s  = {IW{1'b0}};
    for (int k = 0; k < NUM_REQ; k++) begin
      owner_data_s = owner_data_s | (req_data[8*k +: 8] & {8{grant[k]}});
      owner_idx_s  = owner_idx_s | (grant[k] ? IW'(k) : {IW{1'b0}});
    end
  end

  // State register.
  always_ff @(posedge clk50m or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; in LOAD a withdrawn request takes precedence over busy.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (|req) next_state_s = ST_LOAD;
        else      next_state_s = ST_IDLE;
      end
      ST_LOAD: begin
        if (!owner_req_s)  next_state_s = ST_HOLD;
        else if (!tx_busy) next_state_s = ST_WAIT_BUSY;
        else               next_state_s = ST_LOAD;
      end
      ST_WAIT_BUSY: begin
        if (tx_busy) next_state_s = ST_WAIT_DONE;
        else         next_state_s = ST_WAIT_BUSY;
      end
      ST_WAIT_DONE: begin
        if (!tx_busy) next_state_s = last_flag_r ? ST_IDLE : ST_HOLD;
        else          next_state_s = ST_WAIT_DONE;
      end
      ST_HOLD: begin
        if (owner_req_s)        next_state_s = ST_LOAD;
        else if (timeout_hit_s) next_state_s = ST_IDLE;
        else                    next_state_s = ST_HOLD;
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs and owner bookkeeping.
  always_comb begin
    grant_nxt_s      = grant;
    ack_nxt_s        = {NUM_REQ{1'b0}};
    start_nxt_s      = 1'b0;
    data_nxt_s       = tx_data;
    last_owner_nxt_s = last_owner_r;
    last_flag_nxt_s  = last_flag_r;
    case (state_r)
      ST_IDLE: begin
        if (|req) grant_nxt_s = pick_s;
        else      grant_nxt_s = grant;
      end
      ST_LOAD: begin
        if (owner_req_s && !tx_busy) begin
          start_nxt_s     = 1'b1;
          ack_nxt_s       = grant;
          data_nxt_s      = owner_data_s;
          last_flag_nxt_s = owner_last_s;
        end else begin
          start_nxt_s = 1'b0;
        end
      end
      ST_WAIT_BUSY: begin
        grant_nxt_s = grant;
      end
      ST_WAIT_DONE: begin
        if (!tx_busy && last_flag_r) begin
          grant_nxt_s      = {NUM_REQ{1'b0}};
          last_owner_nxt_s = owner_idx_s;
        end else begin
          grant_nxt_s = grant;
        end
      end
      ST_HOLD: begin
        if (!owner_req_s && timeout_hit_s) begin
          grant_nxt_s      = {NUM_REQ{1'b0}};
          last_owner_nxt_s = owner_idx_s;
        end else begin
          grant_nxt_s = grant;
        end
      end
      default: begin
        grant_nxt_s = {NUM_REQ{1'b0}};
      end
    endcase
  end

  // Registered outputs; reset leaves last_owner at the top index so that
  // requester 0 is searched first.
  always_ff @(posedge clk50m or negedge reset_n) begin
    if (!reset_n) begin
      grant        <= {NUM_REQ{1'b0}};
      req_ack      <= {NUM_REQ{1'b0}};
      tx_start     <= 1'b0;
      tx_data      <= 8'h00;
      last_owner_r <= IW'(NUM_REQ - 1);
      last_flag_r  <= 1'b0;
    end else begin
      grant        <= grant_nxt_s;
      req_ack      <= ack_nxt_s;
      tx_start     <= start_nxt_s;
      tx_data      <= data_nxt_s;
      last_owner_r <= last_owner_nxt_s;
      last_flag_r  <= last_flag_nxt_s;
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CW = $clog2(HOLD_TIMEOUT + 1);

  logic [CW-1:0] hold_cnt_r;

  // The counter reads 0 on the first HOLD cycle, so hitting HOLD_TIMEOUT-1
  // revokes the owner exactly HOLD_TIMEOUT cycles after HOLD entry.
  assign timeout_hit_s = (hold_cnt_r == CW'(HOLD_TIMEOUT - 1));

  // HOLD watchdog counter, cleared whenever the FSM is not staying in HOLD.
  always_ff @(posedge clk50m or negedge reset_n) begin
    if (!reset_n) begin
      hold_cnt_r <= {CW{1'b0}};
    end else if (state_r == ST_HOLD && next_state_s == ST_HOLD) begin
      hold_cnt_r <= hold_cnt_r + CW'(1);
    end else begin
      hold_cnt_r <= {CW{1'b0}};
    end
  end

  // Registered revocation pulse.
  always_ff @(posedge clk50m or negedge reset_n) begin
    if (!reset_n) begin
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= (state_r == ST_HOLD) && !owner_req_s && timeout_hit_s;
    end
  end
`else
  assign timeout_hit_s = 1'b0;
  assign timeout_err   = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
// Directed bench for uart_tx_arbiter (NUM_REQ=4, HOLD_TIMEOUT=16). Byte
// sources are small per-requester queues, the transmitter is a 10-cycle busy
// model, and every tx_start is logged for comparison against hand-computed
// expectations. The watchdog test follows UART_ARB_TIMEOUT_EN.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

  localparam int NR       = 4;
  localparam int BUSY_LEN = 10;

  logic        clk50m   = 1'b0;
  logic        reset_n  = 1'b0;
  logic [3:0]  req      = 4'b0;
  logic [3:0]  req_last = 4'b0;
  logic [31:0] req_data = 32'h0;
  logic [3:0]  req_ack;
  logic [3:0]  grant;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy;
  logic        timeout_err;

  bit force_busy = 1'b0;
  bit auto_busy  = 1'b0;
  assign tx_busy = force_busy | auto_busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  uart_tx_arbiter #(
    .NUM_REQ      (NR),
    .HOLD_TIMEOUT (16)
  ) dut (
    .clk50m      (clk50m),
    .reset_n     (reset_n),
    .req         (req),
    .req_last    (req_last),
    .req_data    (req_data),
    .req_ack     (req_ack),
    .grant       (grant),
    .tx_data     (tx_data),
    .tx_start    (tx_start),
    .tx_busy     (tx_busy),
    .timeout_err (timeout_err)
  );

  always #10 clk50m = ~clk50m;

  always @(posedge clk50m) cyc++;

  // Requester queues
  logic [7:0] qd [NR][16];
  logic       ql [NR][16];
  int         qh [NR] = '{default: 0};
  int         qt [NR] = '{default: 0};
  bit         pause [NR] = '{default: 1'b0};
  bit         pause_after [NR] = '{default: 1'b0};

  always @(negedge clk50m) begin
    for (int i = 0; i < NR; i++) begin
      if (req_ack[i] && qh[i] < qt[i]) begin
        qh[i]++;
        if (pause_after[i]) begin
          pause[i]       = 1'b1;
          pause_after[i] = 1'b0;
        end
      end
      req[i]             = (qh[i] < qt[i]) && !pause[i];
      req_data[8*i +: 8] = (qh[i] < qt[i]) ? qd[i][qh[i]] : 8'h00;
      req_last[i]        = (qh[i] < qt[i]) ? ql[i][qh[i]] : 1'b0;
    end
  end

  // Transmitter model: busy for BUSY_LEN cycles after each tx_start
  int busy_cnt = 0;
  int fall_cyc = 0;
  always @(negedge clk50m) begin
    if (tx_start) begin
      busy_cnt  = BUSY_LEN;
      auto_busy = 1'b1;
    end else if (busy_cnt > 0) begin
      busy_cnt--;
      if (busy_cnt == 0) begin
        auto_busy = 1'b0;
        fall_cyc  = cyc;
      end
    end
  end

  // Monitor: log launches, watchdog pulses and the ack invariant
  logic [3:0] lg_grant [32];
  logic [7:0] lg_data  [32];
  logic [3:0] lg_ack   [32];
  int         lg_cyc   [32];
  int         lg_lat   [32];
  int         n_log     = 0;
  int         idle_cyc  = 0;
  int         tmo_cnt   = 0;
  int         tmo_cyc   = 0;
  int         tmo_fall  = 0;
  logic [3:0] tmo_grant = 4'b0;

  always @(negedge clk50m) begin
    if (reset_n) begin
      if (grant == 4'b0) idle_cyc = cyc;
      if (tx_start && n_log < 32) begin
        lg_grant[n_log] = grant;
        lg_data[n_log]  = tx_data;
        lg_ack[n_log]   = req_ack;
        lg_cyc[n_log]   = cyc;
        lg_lat[n_log]   = cyc - idle_cyc;
        n_log++;
      end
      if (timeout_err) begin
        tmo_cnt++;
        tmo_cyc   = cyc;
        tmo_fall  = fall_cyc;
        tmo_grant = grant;
      end
      checks++;
      assert ((req_ack == 4'b0) || (tx_start && $onehot(req_ack))) else begin
        errors++;
        $error("FAIL ack_onehot: observed req_ack=%b tx_start=%b, required zero or one-hot with tx_start", req_ack, tx_start);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk50m);
    #1;
  endtask

  task automatic push(input int i, input logic [7:0] d, input logic l);
    qd[i][qt[i]] = d;
    ql[i][qt[i]] = l;
    qt[i]++;
  endtask

  task automatic wait_log(input int target, input string tag);
    int k = 0;
    while (n_log < target && k < 300) begin
      step();
      k++;
    end
    check(tag, n_log, target);
  endtask

  task automatic wait_quiet(input string tag);
    int k = 0;
    while (!(grant == 4'b0 && tx_busy == 1'b0) && k < 300) begin
      step();
      k++;
    end
    check(tag, {grant, 3'b0, tx_busy}, 8'h00);
  endtask

  task automatic check_entry(input int idx, input logic [3:0] g, input logic [7:0] d, input string tag);
    check({tag, "_grant"}, lg_grant[idx], g);
    check({tag, "_data"},  lg_data[idx],  d);
    check({tag, "_ack"},   lg_ack[idx],   g);
  endtask

  initial begin
    int f_cyc;
    int k;

    // Reset values
    repeat (3) step();
    check("rst_grant",   grant,       4'b0000);
    check("rst_ack",     req_ack,     4'b0000);
    check("rst_start",   tx_start,    1'b0);
    check("rst_data",    tx_data,     8'h00);
    check("rst_timeout", timeout_err, 1'b0);
    reset_n = 1'b1;
    repeat (2) step();

    // Four single-byte requests: strict order 0,1,2,3 with 2-cycle latency
    push(0, 8'h10, 1'b1);
    push(1, 8'h20, 1'b1);
    push(2, 8'h30, 1'b1);
    push(3, 8'h40, 1'b1);
    wait_log(4, "t1_count");
    check_entry(0, 4'b0001, 8'h10, "t1_b0");
    check_entry(1, 4'b0010, 8'h20, "t1_b1");
    check_entry(2, 4'b0100, 8'h30, "t1_b2");
    check_entry(3, 4'b1000, 8'h40, "t1_b3");
    for (int i = 0; i < 4; i++) check("t1_latency", lg_lat[i], 2);

    // Three-byte packet from 1 is not interleaved with requester 2
    wait_quiet("t2_quiet");
    push(1, 8'hA1, 1'b0);
    push(1, 8'hA2, 1'b0);
    push(1, 8'hA3, 1'b1);
    push(2, 8'hB2, 1'b1);
    wait_log(8, "t2_count");
    check_entry(4, 4'b0010, 8'hA1, "t2_a1");
    check_entry(5, 4'b0010, 8'hA2, "t2_a2");
    check_entry(6, 4'b0010, 8'hA3, "t2_a3");
    check_entry(7, 4'b0100, 8'hB2, "t2_b2");

    // Transmitter held busy: grant given, launch only after busy drops
    wait_quiet("t3_quiet");
    force_busy = 1'b1;
    push(0, 8'h5C, 1'b1);
    repeat (20) step();
    check("t3_grant_held", grant, 4'b0001);
    check("t3_no_start", n_log, 8);
    force_busy = 1'b0;
    f_cyc = cyc;
    wait_log(9, "t3_count");
    check_entry(8, 4'b0001, 8'h5C, "t3_b");
    check("t3_start_cycle", lg_cyc[8], f_cyc + 1);

    // Owner 3 stalls mid-packet while requester 0 waits
    wait_quiet("t4_quiet");
    pause_after[3] = 1'b1;
    push(3, 8'hC1, 1'b0);
    push(3, 8'hC2, 1'b1);
    push(0, 8'h0D, 1'b1);
    wait_log(10, "t4_first");
    check_entry(9, 4'b1000, 8'hC1, "t4_c1");
`ifdef UART_ARB_TIMEOUT_EN
    k = 0;
    while (tmo_cnt == 0 && k < 100) begin
      step();
      k++;
    end
    check("t4_tmo_seen", tmo_cnt, 1);
    check("t4_tmo_delay", tmo_cyc - tmo_fall, 17);
    check("t4_tmo_grant", tmo_grant, 4'b0000);
    wait_log(11, "t4_second");
    check_entry(10, 4'b0001, 8'h0D, "t4_d");
    check("t4_d_cycle", lg_cyc[10], tmo_cyc + 2);
    pause[3] = 1'b0;
    wait_log(12, "t4_third");
    check_entry(11, 4'b1000, 8'hC2, "t4_c2");
`else
    k = 0;
    repeat (40) step();
    check("t4_hold_grant", grant, 4'b1000);
    check("t4_no_interleave", n_log, 10);
    check("t4_no_timeout", tmo_cnt, k);
    pause[3] = 1'b0;
    wait_log(12, "t4_rest");
    check_entry(10, 4'b1000, 8'hC2, "t4_c2");
    check_entry(11, 4'b0001, 8'h0D, "t4_d");
`endif

    // Reset during WAIT_DONE of a non-last byte
    wait_quiet("t5_quiet");
    push(1, 8'hE1, 1'b0);
    push(1, 8'hE2, 1'b1);
    wait_log(13, "t5_first");
    check_entry(12, 4'b0010, 8'hE1, "t5_e1");
    repeat (3) step();
    reset_n = 1'b0;
    #1;
    check("t5_rst_grant", grant,    4'b0000);
    check("t5_rst_start", tx_start, 1'b0);
    check("t5_rst_ack",   req_ack,  4'b0000);
    check("t5_rst_data",  tx_data,  8'h00);
    for (int i = 0; i < NR; i++) begin
      qt[i]          = qh[i];
      pause[i]       = 1'b0;
      pause_after[i] = 1'b0;
    end
    repeat (3) step();
    check("t5_quiet_in_reset", n_log, 13);
    reset_n = 1'b1;
    push(1, 8'h61, 1'b1);
    push(2, 8'h62, 1'b1);
    wait_log(15, "t5_after");
    check_entry(13, 4'b0010, 8'h61, "t5_r1");
    check_entry(14, 4'b0100, 8'h62, "t5_r2");

    repeat (5) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
